// File: rtl/gpio_pin_conditioner.sv
// rtl/gpio_pin_conditioner.sv - GPIO pad drive, input sync/debounce, edge events and irq (option: GPIO_DEBOUNCE_EN)
module gpio_pin_conditioner #(
    parameter int HEADER_WIDTH    = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [HEADER_WIDTH-1:0] gpio_dir,
    input  logic [HEADER_WIDTH-1:0] gpio_out,
    output logic [HEADER_WIDTH-1:0] gpio_in,
    input  logic [HEADER_WIDTH-1:0] pad_i,
    output logic [HEADER_WIDTH-1:0] pad_o,
    output logic [HEADER_WIDTH-1:0] pad_oe,
    input  logic [HEADER_WIDTH-1:0] irq_mask,
    input  logic [HEADER_WIDTH-1:0] event_clr,
    output logic [HEADER_WIDTH-1:0] event_status,
    output logic                    irq
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [HEADER_WIDTH-1:0] s1;
    logic [HEADER_WIDTH-1:0] s2;
    logic [HEADER_WIDTH-1:0] din_next;
    logic [HEADER_WIDTH-1:0] rise;
    logic [HEADER_WIDTH-1:0] fall;
    logic [HEADER_WIDTH-1:0] ev_set;

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [HEADER_WIDTH-1:0][CNT_W-1:0] cnt;

    // Counter measures how long s2 has disagreed with the debounced value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < HEADER_WIDTH; k++) begin
                if (s2[k] == gpio_in[k] || cnt[k] == CNT_LAST)
                    cnt[k] <= '0;
                else
                    cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        din_next = gpio_in;
        for (int k = 0; k < HEADER_WIDTH; k++) begin
            if (s2[k] != gpio_in[k] && cnt[k] == CNT_LAST)
                din_next[k] = s2[k];
        end
    end
`else
    always_comb begin
        din_next = s2;
    end
`endif

    always_comb begin
        rise = din_next & ~gpio_in;
        fall = ~din_next & gpio_in;
        if (EDGE_MODE == 1)
            ev_set = rise & gpio_dir;
        else if (EDGE_MODE == 2)
            ev_set = fall & gpio_dir;
        else
            ev_set = (rise | fall) & gpio_dir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_oe       <= '0;
            pad_o        <= '0;
            s1           <= '0;
            s2           <= '0;
            gpio_in      <= '0;
            event_status <= '0;
            irq          <= 1'b0;
        end else begin
            pad_oe       <= ~gpio_dir;
            pad_o        <= gpio_out;
            s1           <= pad_i;
            s2           <= s1;
            gpio_in      <= din_next;
            // A new event outranks a clear arriving on the same edge.
            event_status <= (event_status & ~event_clr) | ev_set;
            irq          <= |(event_status & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_pin_conditioner.sv
// tb/tb_gpio_pin_conditioner.sv - randomized bench for gpio_pin_conditioner against a window-based model
module tb_gpio_pin_conditioner;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int MODE = 1;
`ifdef GPIO_DEBOUNCE_EN
    localparam int D_EFF = D;
`else
    localparam int D_EFF = 1;
`endif
    localparam int CYCLES = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gpio_dir, gpio_out, gpio_in, pad_i, pad_o, pad_oe;
    logic [W-1:0] irq_mask, event_clr, event_status;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] hist[$];
    logic [W-1:0] m_gpio_in, m_ev, m_oe, m_o;
    logic         m_irq;

    gpio_pin_conditioner #(
        .HEADER_WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_MODE(MODE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gpio_dir(gpio_dir),
        .gpio_out(gpio_out),
        .gpio_in(gpio_in),
        .pad_i(pad_i),
        .pad_o(pad_o),
        .pad_oe(pad_oe),
        .irq_mask(irq_mask),
        .event_clr(event_clr),
        .event_status(event_status),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pin value follows the pad once the last D_EFF synchronised samples all disagree with it.
    task automatic model_edge();
        logic [W-1:0] new_in, set_v;
        int n;
        bit stable;
        if (rst) begin
            m_gpio_in = '0; m_ev = '0; m_oe = '0; m_o = '0; m_irq = 1'b0;
            hist.delete();
            repeat (D_EFF + 2) hist.push_back('0);
            return;
        end
        n = hist.size();
        new_in = m_gpio_in;
        for (int k = 0; k < W; k++) begin
            stable = 1'b1;
            for (int j = 0; j < D_EFF; j++)
                if (hist[n-2-j][k] == m_gpio_in[k]) stable = 1'b0;
            if (stable) new_in[k] = ~m_gpio_in[k];
        end
        set_v = '0;
        for (int k = 0; k < W; k++) begin
            if (new_in[k] != m_gpio_in[k] && gpio_dir[k]) begin
                if (MODE == 0) set_v[k] = 1'b1;
                else if (MODE == 1) set_v[k] = new_in[k];
                else set_v[k] = ~new_in[k];
            end
        end
        m_irq     = |(m_ev & irq_mask);
        m_ev      = (m_ev & ~event_clr) | set_v;
        m_oe      = ~gpio_dir;
        m_o       = gpio_out;
        m_gpio_in = new_in;
        hist.push_back(pad_i);
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    task automatic drive_random();
        rst = ($urandom_range(0, 299) == 0);
        for (int k = 0; k < W; k++)
            if ($urandom_range(0, 7) == 0) pad_i[k] = ~pad_i[k];
        if ($urandom_range(0, 19) == 0) gpio_dir = W'($urandom | $urandom);
        if ($urandom_range(0, 29) == 0) irq_mask = W'($urandom);
        gpio_out  = W'($urandom);
        event_clr = W'($urandom & $urandom & $urandom);
    endtask

    initial begin
        rst = 1'b1; pad_i = 16'hFFFF; gpio_dir = '1; gpio_out = '0;
        irq_mask = '1; event_clr = '0;
        model_edge();
        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("pad_oe", 32'(pad_oe), 32'(m_oe));
            check_eq("pad_o", 32'(pad_o), 32'(m_o));
            check_eq("gpio_in", 32'(gpio_in), 32'(m_gpio_in));
            check_eq("event_status", 32'(event_status), 32'(m_ev));
            check_eq("irq", 32'(irq), 32'(m_irq));
            if (c < 1) begin
                rst = 1'b1;
            end else if (c == 1) begin
                rst = 1'b0; gpio_dir = 16'hFFFE; gpio_out = 16'h0001; pad_i = '0;
            end else begin
                drive_random();
            end
            model_edge();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
